// File: rtl/udma_evt_ctrl_if.sv
// uDMA control-block bus: register access strobe/data plus the incoming
// SoC event strobe. The controller side uses the slave modport.
interface udma_evt_ctrl_if #(
    parameter int EVT_W = 8
);
    logic [31:0]      cfg_data_i;
    logic [4:0]       cfg_addr_i;
    logic             cfg_valid_i;
    logic             cfg_rwn_i;
    logic [31:0]      cfg_data_o;
    logic             cfg_ready_o;
    logic             event_valid_i;
    logic [EVT_W-1:0] event_data_i;
    logic             event_ready_o;

    modport slave (
        input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        input  event_valid_i, event_data_i,
        output cfg_data_o, cfg_ready_o, event_ready_o
    );

    modport master (
        output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        output event_valid_i, event_data_i,
        input  cfg_data_o, cfg_ready_o, event_ready_o
    );
endinterface

// File: rtl/udma_evt_ctrl.sv
// uDMA control block: clock gates, self-timed soft resets and N_EVT
// programmable event matchers with divide-by-N pulse output and sticky status.

// One event channel: hit counter and registered divided pulse.
module udma_evt_ctrl_ch (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clr_i,
    input  logic       hit_i,
    input  logic [3:0] div_i,
    output logic       evt_o
);
    logic [3:0] cnt_q, cnt_d;
    logic       evt_q, evt_d;

    // count qualified hits, emit a pulse and wrap when the divider is reached
    always_comb begin
        cnt_d = cnt_q;
        evt_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (hit_i) begin
            if (cnt_q == div_i) begin
                evt_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // channel state registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            evt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign evt_o = evt_q;
endmodule

module udma_evt_ctrl #(
    parameter int N_PERIPHS = 6,
    parameter int N_EVT     = 4,
    parameter int EVT_W     = 8,
    parameter int RST_LEN_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    udma_evt_ctrl_if.slave       bus,
    output logic [N_PERIPHS-1:0] sw_rst_o,
    output logic [N_PERIPHS-1:0] cg_value_o,
    output logic                 cg_core_o,
    output logic [N_EVT-1:0]     event_o
);
    localparam logic [4:0] A_CG     = 5'h00;
    localparam logic [4:0] A_EVT_LO = 5'h01;
    localparam logic [4:0] A_RST    = 5'h02;
    localparam logic [4:0] A_EVT_HI = 5'h03;
    localparam logic [4:0] A_EN     = 5'h04;
    localparam logic [4:0] A_DIV    = 5'h05;
    localparam logic [4:0] A_STAT   = 5'h06;
    localparam logic [4:0] A_RLEN   = 5'h07;

    logic [N_PERIPHS-1:0]            cg_q, cg_d;
    logic [N_PERIPHS-1:0]            rst_q, rst_d;
    logic [RST_LEN_W-1:0]            rlen_q, rlen_d;
    logic [RST_LEN_W-1:0]            cnt_q, cnt_d;
    logic [N_EVT-1:0][EVT_W-1:0]     id_q, id_d;
    logic [N_EVT-1:0]                en_q, en_d;
    logic [N_EVT-1:0][3:0]           div_q, div_d;
    logic [N_EVT-1:0]                stat_q, stat_d;
    logic [N_EVT-1:0]                hit;
    logic [N_PERIPHS-1:0]            wbits;
    logic [31:0]                     rdata;
    logic                            wr, cfg_wr;

    assign wr     = bus.cfg_valid_i & ~bus.cfg_rwn_i;
    // any matcher reconfiguration restarts all dividers and drops this cycle's hits
    assign cfg_wr = wr & (bus.cfg_addr_i == A_EVT_LO || bus.cfg_addr_i == A_EVT_HI ||
                          bus.cfg_addr_i == A_EN     || bus.cfg_addr_i == A_DIV);
    assign wbits  = bus.cfg_data_i[N_PERIPHS-1:0];

    // plain configuration register writes
    always_comb begin
        cg_d   = cg_q;
        id_d   = id_q;
        en_d   = en_q;
        div_d  = div_q;
        rlen_d = rlen_q;
        if (wr) begin
            case (bus.cfg_addr_i)
                A_CG:     cg_d = wbits;
                A_EVT_LO: for (int k = 0; k < N_EVT; k++)
                              if (k < 4) id_d[k] = bus.cfg_data_i[8*(k%4) +: EVT_W];
                A_EVT_HI: for (int k = 0; k < N_EVT; k++)
                              if (k >= 4) id_d[k] = bus.cfg_data_i[8*(k%4) +: EVT_W];
                A_EN:     en_d = bus.cfg_data_i[N_EVT-1:0];
                A_DIV:    for (int k = 0; k < N_EVT; k++) div_d[k] = bus.cfg_data_i[4*k +: 4];
                A_RLEN:   rlen_d = bus.cfg_data_i[RST_LEN_W-1:0];
                default:  ;
            endcase
        end
    end

    // soft reset: level mode when length is 0, otherwise OR-in and time out
    always_comb begin
        rst_d = rst_q;
        cnt_d = cnt_q;
        if (wr && bus.cfg_addr_i == A_RST && rlen_q == '0) begin
            rst_d = wbits;
            cnt_d = '0;
        end else if (wr && bus.cfg_addr_i == A_RST && wbits != '0) begin
            rst_d = rst_q | wbits;
            cnt_d = rlen_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == RST_LEN_W'(1)) rst_d = '0;
        end
    end

    // event matching and sticky status (W1C loses against a same-cycle hit)
    always_comb begin
        for (int k = 0; k < N_EVT; k++)
            hit[k] = bus.event_valid_i & en_q[k] & (bus.event_data_i == id_q[k]) & ~cfg_wr;
        stat_d = stat_q;
        if (wr && bus.cfg_addr_i == A_STAT) stat_d = stat_q & ~bus.cfg_data_i[N_EVT-1:0];
        stat_d = stat_d | hit;
    end

    // register file and soft-reset counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cg_q   <= '0;
            rst_q  <= '0;
            rlen_q <= '0;
            cnt_q  <= '0;
            id_q   <= '0;
            en_q   <= '0;
            div_q  <= '0;
            stat_q <= '0;
        end else begin
            cg_q   <= cg_d;
            rst_q  <= rst_d;
            rlen_q <= rlen_d;
            cnt_q  <= cnt_d;
            id_q   <= id_d;
            en_q   <= en_d;
            div_q  <= div_d;
            stat_q <= stat_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_EVT; g++) begin : g_ch
            udma_evt_ctrl_ch u_ch (
                .clk_i  (clk_i),
                .rstn_i (rstn_i),
                .clr_i  (cfg_wr),
                .hit_i  (hit[g]),
                .div_i  (div_q[g]),
                .evt_o  (event_o[g])
            );
        end
    endgenerate

    // read mux, zero unless a read is strobed
    always_comb begin
        rdata = '0;
        if (bus.cfg_valid_i && bus.cfg_rwn_i) begin
            case (bus.cfg_addr_i)
                A_CG:     rdata[N_PERIPHS-1:0] = cg_q;
                A_EVT_LO: for (int k = 0; k < N_EVT; k++)
                              if (k < 4) rdata[8*(k%4) +: EVT_W] = id_q[k];
                A_RST:    rdata[N_PERIPHS-1:0] = rst_q;
                A_EVT_HI: for (int k = 0; k < N_EVT; k++)
                              if (k >= 4) rdata[8*(k%4) +: EVT_W] = id_q[k];
                A_EN:     rdata[N_EVT-1:0] = en_q;
                A_DIV:    for (int k = 0; k < N_EVT; k++) rdata[4*k +: 4] = div_q[k];
                A_STAT:   rdata[N_EVT-1:0] = stat_q;
                A_RLEN:   rdata[RST_LEN_W-1:0] = rlen_q;
                default:  ;
            endcase
        end
    end

    assign bus.cfg_data_o    = rdata;
    assign bus.cfg_ready_o   = 1'b1;
    assign bus.event_ready_o = 1'b1;
    assign sw_rst_o          = rst_q;
    assign cg_value_o        = cg_q;
    assign cg_core_o         = |cg_q;
endmodule

// File: tb/tb_udma_evt_ctrl.sv
// Bench for udma_evt_ctrl: vector table, directed multi-cycle sequences and
// random traffic compared against a behavioural model.
module tb_udma_evt_ctrl;
    localparam int NP = 6;
    localparam int NE = 4;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    udma_evt_ctrl_if #(.EVT_W(EW)) bus();
    logic [NP-1:0] sw_rst, cg_val;
    logic          cg_core;
    logic [NE-1:0] evt;

    udma_evt_ctrl #(.N_PERIPHS(NP), .N_EVT(NE), .EVT_W(EW), .RST_LEN_W(8)) dut (
        .clk_i(clk), .rstn_i(rstn), .bus(bus),
        .sw_rst_o(sw_rst), .cg_value_o(cg_val), .cg_core_o(cg_core), .event_o(evt)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 50) $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock: drive, sample combinational read data, clock, settle
    task automatic step(input logic v, input logic rwn, input logic [4:0] a,
                        input logic [31:0] d, input logic ev, input logic [7:0] ed);
        bus.cfg_valid_i = v; bus.cfg_rwn_i = rwn; bus.cfg_addr_i = a; bus.cfg_data_i = d;
        bus.event_valid_i = ev; bus.event_data_i = ed;
        #2 last_rd = bus.cfg_data_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();                           step(0, 0, 0, 0, 0, 0);  endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d); step(1, 0, a, d, 0, 0); endtask
    task automatic rd(input logic [4:0] a);          step(1, 1, a, 0, 0, 0);  endtask
    task automatic hit(input logic [7:0] ed);        step(0, 0, 0, 0, 1, ed); endtask

    // async reset: outputs must be zero while held, without waiting for a clock
    task automatic do_reset();
        bus.cfg_valid_i = 0; bus.cfg_rwn_i = 0; bus.cfg_addr_i = 0; bus.cfg_data_i = 0;
        bus.event_valid_i = 0; bus.event_data_i = 0;
        rstn = 1'b0;
        #2;
        check("rst_sw_rst", 32'(sw_rst), 0);
        check("rst_cg", 32'(cg_val), 0);
        check("rst_evt", 32'(evt), 0);
        check("rst_ready", {30'd0, bus.cfg_ready_o, bus.event_ready_o}, 32'd3);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_cg, m_en, m_stat, m_rst, m_rlen, m_evt;
    int unsigned m_id[8], m_div[8], m_hits[8];
    bit m_act;
    int m_until, cyc;

    function automatic void m_reset();
        m_cg = 0; m_en = 0; m_stat = 0; m_rst = 0; m_rlen = 0; m_evt = 0;
        m_act = 0; m_until = 0; cyc = 0;
        for (int k = 0; k < 8; k++) begin m_id[k] = 0; m_div[k] = 0; m_hits[k] = 0; end
    endfunction

    function automatic int unsigned m_read(input int a);
        int unsigned r = 0;
        case (a)
            0: r = m_cg;
            1: for (int k = 0; k < NE && k < 4; k++) r |= m_id[k] << (8 * k);
            2: r = m_rst;
            3: for (int k = 4; k < NE; k++) r |= m_id[k] << (8 * (k - 4));
            4: r = m_en;
            5: for (int k = 0; k < NE; k++) r |= m_div[k] << (4 * k);
            6: r = m_stat;
            7: r = m_rlen;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic void m_update(input bit v, input bit rwn, input int a,
                                     input int unsigned d, input bit ev, input int unsigned ed);
        int unsigned pm = (1 << NP) - 1;
        int unsigned em = (1 << NE) - 1;
        bit wrt = v && !rwn;
        bit cfgw = wrt && (a == 1 || a == 3 || a == 4 || a == 5);
        int unsigned hm = 0;
        int unsigned nevt = 0;
        for (int k = 0; k < NE; k++)
            if (ev && m_en[k] && ed == m_id[k]) hm |= 1 << k;
        if (cfgw) begin
            for (int k = 0; k < NE; k++) m_hits[k] = 0;
            hm = 0;
        end
        for (int k = 0; k < NE; k++)
            if (hm[k]) begin
                m_hits[k]++;
                if (m_hits[k] % (m_div[k] + 1) == 0) nevt |= 1 << k;
            end
        if (wrt && a == 6) m_stat &= ~d & em;
        m_stat |= hm;
        if (wrt && a == 2 && m_rlen == 0) begin
            m_rst = d & pm; m_act = 0;
        end else if (wrt && a == 2 && (d & pm) != 0) begin
            m_rst |= d & pm; m_act = 1; m_until = cyc + int'(m_rlen);
        end else if (m_act && cyc == m_until) begin
            m_rst = 0; m_act = 0;
        end
        if (wrt) begin
            case (a)
                0: m_cg = d & pm;
                1: for (int k = 0; k < NE && k < 4; k++) m_id[k] = (d >> (8 * k)) & 8'hFF;
                3: for (int k = 4; k < NE; k++) m_id[k] = (d >> (8 * (k - 4))) & 8'hFF;
                4: m_en = d & em;
                5: for (int k = 0; k < NE; k++) m_div[k] = (d >> (4 * k)) & 4'hF;
                7: m_rlen = d & 8'hFF;
                default: ;
            endcase
        end
        m_evt = nevt;
        cyc++;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic v, rwn; logic [4:0] a; logic [31:0] d; logic ev; logic [7:0] ed;
        logic [31:0] rd; logic [5:0] rst; logic [5:0] cg; logic core; logic [3:0] evt;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic v, rwn, input logic [4:0] a, input logic [31:0] d,
                                input logic ev, input logic [7:0] ed, input logic [31:0] rdv,
                                input logic [5:0] rst, cg, input logic core, input logic [3:0] e);
        vec_t t;
        t = '{v, rwn, a, d, ev, ed, rdv, rst, cg, core, e};
        return t;
    endfunction

    initial begin
        logic [3:0] ex;
        //                v rwn addr   data           ev  ed     rd     rst   cg   core evt
        tbl.push_back(mk(0, 0, 5'h00, 32'h0,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 0, 5'h00, 32'h21,        0, 8'h00, 32'h0,  6'h0, 6'h21, 1, 4'h0));
        tbl.push_back(mk(1, 1, 5'h00, 32'h0,         0, 8'h00, 32'h21, 6'h0, 6'h21, 1, 4'h0));
        tbl.push_back(mk(1, 0, 5'h00, 32'h0,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 1, 5'h1F, 32'h0,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 0, 5'h02, 32'h05,        0, 8'h00, 32'h0,  6'h5, 6'h00, 0, 4'h0));
        tbl.push_back(mk(0, 0, 5'h00, 32'h0,         0, 8'h00, 32'h0,  6'h5, 6'h00, 0, 4'h0));
        tbl.push_back(mk(0, 0, 5'h00, 32'h0,         0, 8'h00, 32'h0,  6'h5, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 1, 5'h02, 32'h0,         0, 8'h00, 32'h5,  6'h5, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 0, 5'h02, 32'h0,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 0, 5'h01, 32'h12,        0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 0, 5'h04, 32'h1,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(0, 0, 5'h00, 32'h0,         1, 8'h12, 32'h0,  6'h0, 6'h00, 0, 4'h1));
        tbl.push_back(mk(0, 0, 5'h00, 32'h0,         1, 8'h13, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(0, 0, 5'h00, 32'h0,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 1, 5'h06, 32'h0,         0, 8'h00, 32'h1,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 0, 5'h06, 32'h1,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 1, 5'h06, 32'h0,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 1, 5'h01, 32'h0,         0, 8'h00, 32'h12, 6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 0, 5'h1F, 32'hFFFFFFFF,  0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 1, 5'h00, 32'h0,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 1, 5'h07, 32'h0,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(0, 1, 5'h04, 32'h0,         0, 8'h00, 32'h0,  6'h0, 6'h00, 0, 4'h0));
        tbl.push_back(mk(1, 1, 5'h04, 32'h0,         0, 8'h00, 32'h1,  6'h0, 6'h00, 0, 4'h0));

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].rwn, tbl[i].a, tbl[i].d, tbl[i].ev, tbl[i].ed);
            check($sformatf("vec%0d_rd", i), last_rd, tbl[i].rd);
            check($sformatf("vec%0d_rst", i), 32'(sw_rst), 32'(tbl[i].rst));
            check($sformatf("vec%0d_cg", i), 32'(cg_val), 32'(tbl[i].cg));
            check($sformatf("vec%0d_core", i), 32'(cg_core), 32'(tbl[i].core));
            check($sformatf("vec%0d_evt", i), 32'(evt), 32'(tbl[i].evt));
        end

        // soft-reset pulse: L=4, high for exactly 4 cycles after the write
        do_reset();
        wr(5'h07, 4);
        wr(5'h02, 3);
        check("pulse_t1", 32'(sw_rst), 3);
        for (int j = 2; j <= 5; j++) begin
            idle();
            check($sformatf("pulse_t%0d", j), 32'(sw_rst), j <= 4 ? 3 : 0);
        end
        // rewrite during countdown ORs bits and restarts the count
        wr(5'h02, 3);
        check("ext_t1", 32'(sw_rst), 3);
        idle();
        check("ext_t2", 32'(sw_rst), 3);
        wr(5'h02, 4);
        for (int j = 3; j <= 7; j++) begin
            check($sformatf("ext_t%0d", j), 32'(sw_rst), j <= 6 ? 7 : 0);
            idle();
        end
        // write of 0 in pulse mode leaves the running pulse alone
        wr(5'h02, 1);
        wr(5'h02, 0);
        check("zero_wr_keep", 32'(sw_rst), 1);
        idle(); idle();
        check("zero_wr_t4", 32'(sw_rst), 1);
        idle();
        check("zero_wr_end", 32'(sw_rst), 0);
        // async reset mid-countdown
        wr(5'h02, 6'h30);
        idle();
        do_reset();
        idle(); idle(); idle(); idle(); idle();
        check("post_rst_sw", 32'(sw_rst), 0);
        rd(5'h07);
        check("post_rst_len", last_rd, 0);

        // divide by 3 on channel 1
        wr(5'h01, 32'h0000_3400);
        wr(5'h04, 2);
        wr(5'h05, 32'h20);
        for (int j = 1; j <= 7; j++) begin
            hit(8'h34);
            ex = (j == 3 || j == 6) ? 4'b0010 : 4'b0000;
            check($sformatf("div_hit%0d", j), 32'(evt), 32'(ex));
        end
        rd(5'h06);
        check("div_stat", last_rd, 2);
        wr(5'h06, 2);
        rd(5'h06);
        check("div_stat_w1c", last_rd, 0);

        // two channels on one id; config write in a hit cycle discards hits
        do_reset();
        wr(5'h01, 32'h0055_0055);
        wr(5'h04, 5);
        wr(5'h05, 1);
        hit(8'h55);
        check("multi_hit1", 32'(evt), 4);
        step(1, 0, 5'h04, 5, 1, 8'h55);
        check("cfg_hit_drop", 32'(evt), 0);
        hit(8'h55);
        check("multi_hit2", 32'(evt), 4);
        hit(8'h55);
        check("multi_hit3", 32'(evt), 5);
        step(1, 0, 5'h06, 32'hF, 1, 8'h55);
        rd(5'h06);
        check("w1c_vs_hit", last_rd, 5);
        wr(5'h06, 32'hF);
        step(1, 0, 5'h04, 5, 1, 8'h55);
        rd(5'h06);
        check("cfg_hit_nostat", last_rd, 0);

        // random traffic against the model
        do_reset();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            bit v, rwn, ev;
            logic [4:0] a;
            logic [31:0] d, er;
            logic [7:0] ed;
            v   = ($urandom_range(0, 9) < 4);
            rwn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            d   = $urandom;
            if (a == 7) d = $urandom_range(0, 6);
            if (a == 5) d = d & 32'h3333_3333;
            if (a == 4) d = $urandom_range(0, 15);
            if (a == 2 && $urandom_range(0, 3) == 0) d = 0;
            ev  = 1'($urandom_range(0, 1));
            ed  = $urandom_range(0, 1) ? 8'(m_id[$urandom_range(0, NE - 1)]) : 8'($urandom);
            er  = (v && rwn) ? m_read(int'(a)) : 0;
            step(v, rwn, a, d, ev, ed);
            m_update(v, rwn, int'(a), d, ev, ed);
            check("rnd_rd", last_rd, er);
            check("rnd_rst", 32'(sw_rst), m_rst);
            check("rnd_cg", 32'(cg_val), m_cg);
            check("rnd_core", 32'(cg_core), 32'(m_cg != 0));
            check("rnd_evt", 32'(evt), m_evt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
